// File: rtl/cpu_pkg.sv
// cpu_pkg: shared ALU opcodes, mul/div op codes and sequencer state encoding.
package cpu_pkg;
  localparam logic [4:0] ALU_ADD  = 5'b00000;
  localparam logic [4:0] ALU_NOP  = 5'b00001;
  localparam logic [4:0] ALU_SUB  = 5'b00010;
  localparam logic [4:0] ALU_AND  = 5'b00011;
  localparam logic [4:0] ALU_OR   = 5'b00100;
  localparam logic [4:0] ALU_XOR  = 5'b00101;
  localparam logic [4:0] ALU_SLL  = 5'b00110;
  localparam logic [4:0] ALU_SRL  = 5'b00111;
  localparam logic [4:0] ALU_SRA  = 5'b01000;
  localparam logic [4:0] ALU_SLT  = 5'b01001;
  localparam logic [4:0] ALU_SLTU = 5'b01010;
  localparam logic [1:0] MD_MUL   = 2'b00;
  localparam logic [1:0] MD_MULHU = 2'b01;
  localparam logic [1:0] MD_DIVU  = 2'b10;
  localparam logic [1:0] MD_REMU  = 2'b11;
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2} md_state_e;
endpackage

// File: rtl/muldiv_step.sv
// muldiv_step: one shift-add multiply or restoring divide iteration using the shared ALU.
module muldiv_step
  import cpu_pkg::*;
(
  input  logic        i_run,
  input  logic [1:0]  i_op,
  input  logic [31:0] i_hi,
  input  logic [31:0] i_lo,
  input  logic [31:0] i_b,
  input  logic [31:0] i_alu_result,
  output logic [4:0]  o_alu_op,
  output logic [31:0] o_alu_in1,
  output logic [31:0] o_alu_in2,
  output logic [31:0] o_hi_nxt,
  output logic [31:0] o_lo_nxt
);
  logic        w_div;
  logic        w_carry;
  logic        w_ge;
  logic [31:0] w_rs;
  logic [31:0] w_sum;
  assign w_div   = i_op[1];
  assign w_rs    = {i_hi[30:0], i_lo[31]};
  // hi[31] is the 33rd remainder bit: when set the shifted remainder always exceeds B
  assign w_ge    = i_hi[31] | (w_rs >= i_b);
  assign w_carry = i_lo[0] & (i_alu_result < i_hi);
  assign w_sum   = i_lo[0] ? i_alu_result : i_hi;
  always_comb begin
    o_alu_op  = !i_run ? ALU_NOP : w_div ? ALU_SUB : ALU_ADD;
    o_alu_in1 = !i_run ? '0 : w_div ? w_rs : i_hi;
    o_alu_in2 = i_run ? i_b : '0;
    o_hi_nxt  = w_div ? (w_ge ? i_alu_result : w_rs) : {w_carry, w_sum[31:1]};
    o_lo_nxt  = w_div ? {i_lo[30:0], w_ge} : {w_sum[0], i_lo[31:1]};
  end
endmodule

// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative unsigned MUL/MULHU/DIVU/REMU sequencer driving the shared EX-stage ALU.
module muldiv_seq
  import cpu_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int ITER = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      alu_op,
  output logic [XLEN-1:0] alu_in1,
  output logic [XLEN-1:0] alu_in2,
  input  logic [XLEN-1:0] alu_result
);
  localparam int CW = $clog2(ITER) + 1;
  md_state_e       r_state;
  md_state_e       w_state_nxt;
  logic [CW-1:0]   r_cnt;
  logic [XLEN-1:0] r_hi;
  logic [XLEN-1:0] r_lo;
  logic [XLEN-1:0] r_b;
  logic [1:0]      r_op;
  logic [XLEN-1:0] r_result;
  logic            r_done;
  logic            w_run;
  logic            w_accept;
  logic            w_last;
  logic [XLEN-1:0] w_hi_nxt;
  logic [XLEN-1:0] w_lo_nxt;
  assign w_run    = r_state == S_RUN;
  assign w_accept = r_state == S_IDLE && start && !flush;
  assign w_last   = w_run && r_cnt == CW'(ITER - 1) && !flush;
  muldiv_step u_step (
    .i_run       (w_run),
    .i_op        (r_op),
    .i_hi        (r_hi),
    .i_lo        (r_lo),
    .i_b         (r_b),
    .i_alu_result(alu_result),
    .o_alu_op    (alu_op),
    .o_alu_in1   (alu_in1),
    .o_alu_in2   (alu_in2),
    .o_hi_nxt    (w_hi_nxt),
    .o_lo_nxt    (w_lo_nxt)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end
  always_comb begin
    w_state_nxt = S_IDLE;
    if (!flush)
      w_state_nxt = r_state == S_IDLE ? (start ? S_RUN : S_IDLE) :
                    w_run ? (w_last ? S_DONE : S_RUN) : S_IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_b      <= '0;
      r_op     <= '0;
      r_result <= '0;
      r_done   <= 1'b0;
    end else begin
      r_done <= w_state_nxt == S_DONE;
      if (w_accept) begin
        r_op  <= op;
        r_b   <= src_b;
        r_hi  <= '0;
        r_lo  <= src_a;
        r_cnt <= '0;
      end else if (w_run) begin
        r_hi  <= w_hi_nxt;
        r_lo  <= w_lo_nxt;
        r_cnt <= r_cnt + 1'b1;
      end
      // op[0] selects the high half (MULHU) or remainder (REMU)
      if (w_last) r_result <= r_op[0] ? w_hi_nxt : w_lo_nxt;
    end
  end
  assign busy   = r_state != S_IDLE;
  assign done   = r_done;
  assign result = r_result;
endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: directed checks of muldiv_seq with a behavioural model of the shared ALU.
module tb_muldiv_seq;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] src_a = '0;
  logic [31:0] src_b = '0;
  logic        flush = 1'b0;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic [4:0]  alu_op;
  logic [31:0] alu_in1;
  logic [31:0] alu_in2;
  logic [31:0] alu_result;
  int          n_err = 0;
  int          n_chk = 0;
  logic        saw_done;

  muldiv_seq dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .src_a(src_a), .src_b(src_b),
    .flush(flush), .busy(busy), .done(done), .result(result), .alu_op(alu_op),
    .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_result(alu_result)
  );

  always #5 clk = ~clk;
  assign alu_result = alu_op == 5'b00000 ? alu_in1 + alu_in2 :
                      alu_op == 5'b00010 ? alu_in1 - alu_in2 : 32'h0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp);
    start = 1'b1; op = o; src_a = a; src_b = b;
    tick();
    start = 1'b0; src_a = $urandom; src_b = $urandom;
    chk({tag, "_busy1"}, {31'b0, busy}, 32'd1);
    for (int c = 2; c <= 34; c++) begin
      tick();
      if (c == 32) chk({tag, "_done32"}, {31'b0, done}, 32'd0);
      if (c == 33) begin
        chk({tag, "_done33"}, {31'b0, done}, 32'd1);
        chk({tag, "_busy33"}, {31'b0, busy}, 32'd1);
        chk({tag, "_res"}, result, exp);
      end
      if (c == 34) begin
        chk({tag, "_busy34"}, {31'b0, busy}, 32'd0);
        chk({tag, "_done34"}, {31'b0, done}, 32'd0);
      end
    end
  endtask

  initial begin
    tick();
    tick();
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_res", result, 32'd0);
    chk("rst_aluop", {27'b0, alu_op}, 32'd1);
    chk("rst_in1", alu_in1, 32'd0);
    rst_n = 1'b1;
    tick();
    run_op("mul7x6", 2'b00, 32'd7, 32'd6, 32'd42);
    chk("idle_aluop", {27'b0, alu_op}, 32'd1);
    run_op("mulhu_ff", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    run_op("mul_ff", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001);
    run_op("divu100_7", 2'b10, 32'd100, 32'd7, 32'd14);
    run_op("remu100_7", 2'b11, 32'd100, 32'd7, 32'd2);
    run_op("divu_msb", 2'b10, 32'h8000_0000, 32'd1, 32'h8000_0000);
    run_op("divu_by0", 2'b10, 32'd123, 32'd0, 32'hFFFF_FFFF);
    run_op("remu_by0", 2'b11, 32'd123, 32'd0, 32'd123);
    // flush at RUN cycle 10, result must keep 123
    start = 1'b1; op = 2'b00; src_a = 32'd3; src_b = 32'd5;
    tick();
    start = 1'b0;
    chk("fl_aluop_run", {27'b0, alu_op}, 32'd0);
    for (int c = 2; c <= 10; c++) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("fl_busy", {31'b0, busy}, 32'd0);
    saw_done = 1'b0;
    for (int c = 0; c < 30; c++) begin
      saw_done |= done;
      tick();
    end
    chk("fl_nodone", {31'b0, saw_done}, 32'd0);
    chk("fl_res", result, 32'd123);
    // flush beats start in IDLE
    start = 1'b1; flush = 1'b1;
    tick();
    start = 1'b0; flush = 1'b0;
    chk("fl_start_busy", {31'b0, busy}, 32'd0);
    run_op("mul2x2", 2'b00, 32'd2, 32'd2, 32'd4);
    // restart while busy is ignored; async reset mid-operation
    start = 1'b1; op = 2'b10; src_a = 32'd1000; src_b = 32'd10;
    tick();
    start = 1'b0;
    saw_done = 1'b0;
    for (int c = 2; c <= 20; c++) begin
      if (c == 5) begin start = 1'b1; op = 2'b00; src_a = 32'd9; src_b = 32'd9; end
      if (c == 6) start = 1'b0;
      if (c == 10) begin
        chk("rs_aluop", {27'b0, alu_op}, 32'd2);
        chk("rs_in2", alu_in2, 32'd10);
      end
      saw_done |= done;
      tick();
    end
    chk("rs_busy_pre", {31'b0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rs_res", result, 32'd0);
    chk("rs_busy", {31'b0, busy}, 32'd0);
    chk("rs_aluop0", {27'b0, alu_op}, 32'd1);
    chk("rs_in2_0", alu_in2, 32'd0);
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 40; c++) begin
      saw_done |= done;
      tick();
    end
    chk("rs_nodone", {31'b0, saw_done}, 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
